// File: rtl/pilsr_ctrl.sv
// Sequencing controller for a parallel-in, left-shift register: accepts words over
// valid/ready, drives load/shift controls and emits a framed MSB-first serial stream.
module pilsr_ctrl #(
    parameter int WIDTH    = 4,
    parameter int IDLE_GAP = 1
) (
    input  logic             c,
    input  logic             r,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             fill_bit,
    input  logic             flush,
    output logic [WIDTH-1:0] sr_par,
    output logic             sr_load,
    output logic             sr_shift_en,
    output logic             sr_shift_in,
    input  logic             sr_shift_out,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy,
    output logic [7:0]       words_sent
);

    localparam int BCNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);
    localparam logic [3:0]        GAP_LAST  = 4'(IDLE_GAP - 1);

    logic [1:0]        state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q,  bcnt_d;
    logic [3:0]        gcnt_q,  gcnt_d;
    logic [WIDTH-1:0]  par_q,   par_d;
    logic              fill_q,  fill_d;
    logic [7:0]        words_q, words_d;

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first so no latch is inferred.
        state_d = state_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        par_d   = par_q;
        fill_d  = fill_q;
        words_d = words_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    par_d   = in_data;
                    fill_d  = fill_bit;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    bcnt_d  = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (bcnt_q == BCNT_LAST) begin
                    words_d = words_q + 8'd1;
                    gcnt_d  = '0;
                    state_d = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 4'd1;
                end
            end
        endcase
    end

    // Reset clears the captured word too, so sr_par reads 0 straight out of reset.
    always_ff @(posedge c) begin
        if (!r) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            par_q   <= '0;
            fill_q  <= 1'b0;
            words_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            par_q   <= par_d;
            fill_q  <= fill_d;
            words_q <= words_d;
        end
    end

    // The word is only presented to the register while it is being loaded or shifted.
    assign sr_par      = (state_q == ST_LOAD || state_q == ST_SHIFT) ? par_q : '0;
    assign sr_load     = (state_q == ST_LOAD);
    assign sr_shift_en = (state_q == ST_SHIFT);
    assign sr_shift_in = (state_q == ST_SHIFT) & fill_q;
    assign ser_bit     = sr_shift_out;
    assign ser_valid   = (state_q == ST_SHIFT);
    assign ser_last    = (state_q == ST_SHIFT) && (bcnt_q == BCNT_LAST);
    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign words_sent  = words_q;

endmodule

// File: tb/tb_pilsr_ctrl.sv
// Directed bench for pilsr_ctrl with a behavioural pilsr register attached.
module tb_pilsr_ctrl;

    logic       c = 1'b0;
    logic       r = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       fill_bit = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] sr_par;
    logic       sr_load;
    logic       sr_shift_en;
    logic       sr_shift_in;
    logic       sr_shift_out;
    logic       ser_bit;
    logic       ser_valid;
    logic       ser_last;
    logic       busy;
    logic [7:0] words_sent;

    logic [3:0] sr_reg = '0;
    logic [7:0] exp_words = '0;
    int checks = 0;
    int errors = 0;

    pilsr_ctrl #(.WIDTH(4), .IDLE_GAP(1)) dut (
        .c(c), .r(r),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .fill_bit(fill_bit), .flush(flush),
        .sr_par(sr_par), .sr_load(sr_load), .sr_shift_en(sr_shift_en),
        .sr_shift_in(sr_shift_in), .sr_shift_out(sr_shift_out),
        .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_last(ser_last),
        .busy(busy), .words_sent(words_sent)
    );

    always #5 c = ~c;

    // Attached 4-bit parallel-in, left-shift register.
    always @(posedge c) begin
        if (sr_load)          sr_reg <= sr_par;
        else if (sr_shift_en) sr_reg <= {sr_reg[2:0], sr_shift_in};
    end
    assign sr_shift_out = sr_reg[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, in_ready, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " sr_ctl"}, {sr_load, sr_shift_en, sr_shift_in}, 0);
        check({tag, " sr_par"}, sr_par, 0);
        check({tag, " ser_valid"}, ser_valid, 0);
        check({tag, " ser_last"}, ser_last, 0);
        check({tag, " words"}, words_sent, 0);
    endtask

    // Starts in the LOAD cycle; ends in the first IDLE cycle after the gap.
    task automatic follow_word(input logic [3:0] d, input logic f, input string tag);
        check({tag, " load"}, {sr_load, sr_shift_en}, 2'b10);
        check({tag, " par"}, sr_par, d);
        check({tag, " busy"}, busy, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            check({tag, " shift ctl"}, {sr_load, sr_shift_en, sr_shift_in}, {2'b01, f});
            check({tag, " ser_valid"}, ser_valid, 1);
            check({tag, " ser_bit"}, ser_bit, d[3-k]);
            check({tag, " ser_last"}, ser_last, (k == 3));
            check({tag, " in_ready"}, in_ready, 0);
            tick();
        end
        exp_words = exp_words + 8'd1;
        check({tag, " gap outs"}, {sr_load, sr_shift_en, sr_shift_in, ser_valid, ser_last, in_ready}, 0);
        check({tag, " reg fill"}, sr_reg, {4{f}});
        check({tag, " words"}, words_sent, exp_words);
        tick();
        check({tag, " idle"}, {in_ready, busy}, 2'b10);
    endtask

    task automatic run_word(input logic [3:0] d, input logic f, input string tag);
        in_data = d; fill_bit = f; in_valid = 1'b1;
        check({tag, " ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        follow_word(d, f, tag);
    endtask

    initial begin
        int       load_cyc[$];
        logic     bits[$];
        logic [7:0] exp_bits;

        // Reset with a pending request.
        r = 1'b0; in_valid = 1'b1; in_data = 4'd9;
        tick();
        check_reset_outputs("rst1");
        tick();
        check_reset_outputs("rst2");
        in_valid = 1'b0; r = 1'b1;
        tick();
        check_reset_outputs("rst_rel");

        run_word(4'd7, 1'b0, "single");
        check("single reg0", sr_reg, 4'd0);

        // Back-to-back with in_valid held high.
        in_data = 4'd4; fill_bit = 1'b1; in_valid = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            tick();
            check("b2b excl", sr_load & sr_shift_en, 0);
            if (ser_valid) bits.push_back(ser_bit);
            if (sr_load) begin
                load_cyc.push_back(cyc);
                if (load_cyc.size() == 1) begin
                    in_data = 4'd5; fill_bit = 1'b0;
                end else begin
                    check("b2b reg15", sr_reg, 4'd15);
                    in_valid = 1'b0;
                end
            end
        end
        exp_words = exp_words + 8'd2;
        exp_bits = 8'b0100_0101;
        check("b2b nbits", bits.size(), 8);
        for (int i = 0; i < 8 && i < bits.size(); i++)
            check("b2b bit", bits[i], exp_bits[7-i]);
        check("b2b loads", load_cyc.size(), 2);
        if (load_cyc.size() == 2) check("b2b spacing", load_cyc[1] - load_cyc[0], 7);
        check("b2b reg0", sr_reg, 4'd0);
        check("b2b words", words_sent, exp_words);

        // Request during SHIFT is ignored, then accepted at the first IDLE edge.
        in_data = 4'd3; fill_bit = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ign load", sr_load, 1);
        tick();
        check("ign bit0", ser_bit, 0);
        tick();
        in_data = 4'd14; fill_bit = 1'b1; in_valid = 1'b1;
        check("ign ready", in_ready, 0);
        check("ign bit1", ser_bit, 0);
        tick();
        check("ign bit2", ser_bit, 1);
        check("ign par", sr_par, 4'd3);
        tick();
        check("ign bit3", {ser_bit, ser_last}, 2'b11);
        tick();
        exp_words = exp_words + 8'd1;
        check("ign gap", {in_ready, busy, sr_load}, 3'b010);
        check("ign words", words_sent, exp_words);
        tick();
        check("ign idle", in_ready, 1);
        tick();
        in_valid = 1'b0;
        follow_word(4'd14, 1'b1, "ign14");

        // Flush in the second SHIFT cycle.
        in_data = 4'd6; fill_bit = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("fl bit0", {ser_valid, ser_bit}, 2'b10);
        tick();
        flush = 1'b1;
        check("fl bit1", {ser_valid, ser_bit}, 2'b11);
        tick();
        flush = 1'b0;
        check("fl idle", {in_ready, busy, ser_valid}, 3'b100);
        check("fl words", words_sent, exp_words);
        run_word(4'd13, 1'b0, "fl13");

        // Reset during LOAD.
        in_data = 4'd10; fill_bit = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mr load", sr_load, 1);
        r = 1'b0;
        tick();
        r = 1'b1;
        check_reset_outputs("mr");
        exp_words = '0;

        // Wrap of the completed-word counter.
        for (int w = 0; w < 256; w++) begin
            run_word(4'(w), w[4], "wrap");
            if (w == 254) check("wrap 255", words_sent, 8'd255);
        end
        check("wrap 0", words_sent, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
